// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2
  } arb_state_e;

  localparam logic [3:0] WSTRB_WORD      = 4'b1111;
  localparam int         TIMEOUT_CYC_DEF = 255;
  localparam int         TO_CNT_W        = 16;

endpackage

// File: rtl/mem_arbiter_byte_lane.sv
// Combinational byte-lane steering: store strobes/replicated data and
// zero-extended byte extraction for lbu.
module byte_lane
  import mem_arb_pkg::*;
(
  input  logic        i_we,
  input  logic        i_byte,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_ld_lane,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rbyte
);

  always_comb begin
    o_wstrb = 4'b0000;
    if (i_we) begin
      o_wstrb = i_byte ? (4'b0001 << i_st_lane) : WSTRB_WORD;
    end
  end

  assign o_wdata = i_byte ? {4{i_wdata[7:0]}} : i_wdata;
  assign o_rbyte = {24'h0, i_rdata[{i_ld_lane, 3'b000} +: 8]};

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Optional bounded wait for mem_ready enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no access outstanding; grants load/store first, then fetch
// IF_BUSY | fetch presented to memory, waiting for mem_ready
// LS_BUSY | load/store presented to memory, waiting for mem_ready
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic              ls_byte,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  arb_state_e        r_state, w_next;
  logic              w_grant_ls, w_grant_if, w_done, w_timeout;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_byte;
  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_ls_rdata;
  logic [3:0]        r_wstrb;
  logic              r_if_valid, r_ls_valid;
  logic [3:0]        w_st_wstrb;
  logic [31:0]       w_st_wdata, w_ld_byte;

  byte_lane u_byte_lane (
    .i_we      (ls_we),
    .i_byte    (ls_byte),
    .i_st_lane (ls_addr[1:0]),
    .i_wdata   (ls_wdata),
    .i_ld_lane (r_lane),
    .i_rdata   (mem_rdata),
    .o_wstrb   (w_st_wstrb),
    .o_wdata   (w_st_wdata),
    .o_rbyte   (w_ld_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A requester whose valid is high this cycle is still holding req; mask it.
  always_comb begin
    w_next     = r_state;
    w_grant_ls = 1'b0;
    w_grant_if = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ls_req && !r_ls_valid) begin
          w_next     = LS_BUSY;
          w_grant_ls = 1'b1;
        end else if (if_req && !r_if_valid) begin
          w_next     = IF_BUSY;
          w_grant_if = 1'b1;
        end
      end
      IF_BUSY, LS_BUSY: begin
        if (mem_ready || w_timeout) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= '0;
      r_wstrb    <= 4'b0000;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      if (w_grant_ls) begin
        r_addr  <= ls_addr & ALIGN_MASK;
        r_we    <= ls_we;
        r_byte  <= ls_byte;
        r_lane  <= ls_addr[1:0];
        r_wdata <= w_st_wdata;
        r_wstrb <= w_st_wstrb;
      end else if (w_grant_if) begin
        r_addr  <= if_addr & ALIGN_MASK;
        r_we    <= 1'b0;
        r_byte  <= 1'b0;
        r_lane  <= 2'b00;
        r_wdata <= '0;
        r_wstrb <= 4'b0000;
      end
      if (w_done) begin
        if (r_state == LS_BUSY) begin
          r_ls_valid <= 1'b1;
          r_ls_rdata <= w_timeout ? '0 : (r_byte ? w_ld_byte : mem_rdata);
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= w_timeout ? '0 : mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_cnt;
  logic                r_err;

  assign w_timeout = (r_state != IDLE) && !mem_ready &&
                     (r_cnt == TO_CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant_ls || w_grant_if)          r_cnt <= '0;
      else if (r_state != IDLE && !mem_ready) r_cnt <= r_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign mem_req   = (r_state != IDLE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign if_valid  = r_if_valid;
  assign ls_valid  = r_ls_valid;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign stall     = (if_req & ~r_if_valid) | (ls_req & ~r_ls_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner
// sequences and randomized transactions against a reference model.
module tb_mem_arbiter;

  localparam int TB_TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, ls_byte = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        if_valid, ls_valid, stall, mem_req, mem_we, err;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_byte(ls_byte), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err(err)
  );

  typedef struct {
    bit          is_if;
    bit          we;
    bit          byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit is_if, input bit we, input bit byt,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay,
                              input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    vec_t v;
    v.is_if = is_if; v.we = we; v.byt = byt; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.e_addr = e_addr; v.e_wstrb = e_wstrb;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference behaviour from the addressing/lane rules, in plain arithmetic.
  function automatic vec_t ref_model(input bit is_if, input bit we, input bit byt,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int delay);
    int unsigned lane;
    vec_t v;
    lane = addr % 4;
    v = mk(is_if, we, byt, addr, wdata, rdata, delay, '0, '0, '0, '0);
    v.e_addr  = addr - lane;
    v.e_wstrb = (is_if || !we) ? 4'd0 : (byt ? 4'(1 << lane) : 4'd15);
    v.e_wdata = byt ? (wdata % 256) * 32'h01010101 : wdata;
    v.e_rdata = (is_if || !byt) ? rdata : (rdata >> (8 * lane)) % 256;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    if_req = v.is_if; ls_req = !v.is_if; ls_we = v.is_if ? 1'b0 : v.we;
    ls_byte = v.byt; if_addr = v.addr; ls_addr = v.addr; ls_wdata = v.wdata;
    mem_ready = 1'b0;
    #1;
    chk("stall_req", stall, 1);
    chk("mem_req_idle", mem_req, 0);
    for (int c = 0; c <= v.delay; c++) begin
      @(negedge clk);
      mem_ready = (c == v.delay);
      mem_rdata = (c == v.delay) ? v.rdata : $urandom;
      #1;
      chk("mem_req_busy", mem_req, 1);
      chk("mem_addr", mem_addr, v.e_addr);
      chk("mem_we", mem_we, 32'(!v.is_if && v.we));
      if (v.is_if || v.we) chk("mem_wstrb", mem_wstrb, v.e_wstrb);
      if (!v.is_if && v.we) chk("mem_wdata", mem_wdata, v.e_wdata);
      chk("stall_busy", stall, 1);
      chk("valid_busy", if_valid | ls_valid, 0);
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    if (v.is_if) begin
      chk("if_valid", if_valid, 1);
      chk("ls_valid_idle", ls_valid, 0);
      chk("if_rdata", if_rdata, v.e_rdata);
    end else begin
      chk("ls_valid", ls_valid, 1);
      chk("if_valid_idle", if_valid, 0);
      if (!v.we) chk("ls_rdata", ls_rdata, v.e_rdata);
    end
    chk("stall_done", stall, 0);
    chk("mem_req_done", mem_req, 0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    #1;
    chk("valid_once", if_valid | ls_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          if we by addr          wdata         rdata         dly e_addr        strb   e_wdata       e_rdata
    tbl[0] = mk(1, 0, 0, 32'h00000000, 32'h0,        32'h00500093, 0, 32'h00000000, 4'h0, 32'h0,        32'h00500093);
    tbl[1] = mk(0, 1, 1, 32'h00001003, 32'h000000AB, 32'h0,        0, 32'h00001000, 4'h8, 32'hABABABAB, 32'h0);
    tbl[2] = mk(0, 0, 1, 32'h00001002, 32'h0,        32'h11223344, 0, 32'h00001000, 4'h0, 32'h0,        32'h00000022);
    tbl[3] = mk(0, 0, 0, 32'h00000104, 32'h0,        32'hDEADBEEF, 0, 32'h00000104, 4'h0, 32'h0,        32'hDEADBEEF);
    tbl[4] = mk(0, 1, 0, 32'h00000208, 32'hCAFEF00D, 32'h0,        5, 32'h00000208, 4'hF, 32'hCAFEF00D, 32'h0);
    tbl[5] = mk(0, 0, 0, 32'h0000030A, 32'h0,        32'h12345678, 2, 32'h00000308, 4'h0, 32'h0,        32'h12345678);
    tbl[6] = mk(0, 0, 1, 32'h00002001, 32'h0,        32'hA1B2C3D4, 1, 32'h00002000, 4'h0, 32'h0,        32'h000000C3);
    tbl[7] = mk(0, 1, 1, 32'h00000040, 32'h1234567F, 32'h0,        0, 32'h00000040, 4'h1, 32'h7F7F7F7F, 32'h0);
    tbl[8] = mk(1, 0, 0, 32'h00000007, 32'h0,        32'h00A00113, 1, 32'h00000004, 4'h0, 32'h0,        32'h00A00113);
    tbl[9] = mk(0, 0, 1, 32'h00001003, 32'h0,        32'h11223344, 3, 32'h00001000, 4'h0, 32'h0,        32'h00000011);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valids", if_valid | ls_valid, 0);
    chk("rst_rdata", if_rdata | ls_rdata, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Both requesters at once: load/store first, fetch granted in ls_valid cycle.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200; ls_req = 1'b1; ls_we = 1'b0; ls_byte = 1'b0;
    ls_addr = 32'h104;
    #1 chk("both_stall", stall, 1);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk("both_ls_addr", mem_addr, 32'h104);
    chk("both_ls_we", mem_we, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("both_ls_valid", ls_valid, 1);
    chk("both_ls_rdata", ls_rdata, 32'hDEADBEEF);
    chk("both_if_stall", stall, 1);
    ls_req = 1'b0;
    @(negedge clk);
    #1 chk("both_if_req", mem_req, 1);
    chk("both_if_addr", mem_addr, 32'h200);
    chk("both_if_nvalid", if_valid, 0);
    mem_ready = 1'b1; mem_rdata = 32'h00A00093;
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("both_if_valid", if_valid, 1);
    chk("both_if_rdata", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    @(negedge clk);
    #1 chk("both_if_once", if_valid, 0);

    // Requester drops req mid-transaction; access still completes.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_byte = 1'b1; ls_addr = 32'h1001;
    @(negedge clk);
    ls_req = 1'b0;
    #1 chk("drop_mem_req", mem_req, 1);
    chk("drop_stall", stall, 0);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hAABBCCDD;
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("drop_valid", ls_valid, 1);
    chk("drop_rdata", ls_rdata, 32'h000000CC);

`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_byte = 1'b0; ls_addr = 32'h500; mem_ready = 1'b0;
    for (int c = 0; c < TB_TO; c++) begin
      @(negedge clk);
      #1 chk("to_busy", mem_req, 1);
    end
    @(negedge clk);
    #1 chk("to_mem_req", mem_req, 0);
    chk("to_valid", ls_valid, 1);
    chk("to_rdata", ls_rdata, 0);
    chk("to_err", err, 1);
    ls_req = 1'b0;
    run_txn(tbl[3]);
    chk("to_err_sticky", err, 1);
`else
    chk("err_off", err, 0);
`endif

    // Reset in the middle of LS_BUSY.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_byte = 1'b0; ls_addr = 32'h300;
    ls_wdata = 32'h55AA55AA; mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst_req", mem_req, 1);
    rst_n = 1'b0;
    #1 chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    chk("rst_mid_wstrb", mem_wstrb, 0);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_rdata", if_rdata | ls_rdata, 0);
    chk("rst_mid_err", err, 0);
    ls_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1 chk("post_rst_quiet", {30'd0, if_valid | ls_valid, mem_req}, 0);
    end
    mem_ready = 1'b0;
    run_txn(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      bit is_if, we, byt;
      is_if = ($urandom_range(0, 3) == 0);
      we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      byt   = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      v = ref_model(is_if, we, byt, $urandom, $urandom, $urandom, $urandom_range(0, 3));
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
